reg_dump_sequencer: RTL and testbench

//   Hardware counterpart of the simulation test harness around processor/regfile/ROM/RAM.
//   Run phase: counts processor cycles; logs every regfile write (rwe && rd!=0) as a trace record.

---
 rtl/reg_dump_sequencer_pkg.sv | 36 +++
 rtl/reg_dump_sequencer_if.sv | 29 ++
 rtl/reg_dump_sequencer_fifo.sv | 47 ++++
 rtl/reg_dump_sequencer.sv | 141 ++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dump_sequencer_pkg.sv
// Shared types for the register-dump sequencer: controller states and the
// 46-bit record that carries both write-trace and register-dump entries.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        SETTLE,
        EMIT,
        DONE
    } state_t;

    localparam logic REC_TRACE = 1'b0;
    localparam logic REC_DUMP  = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [7:0]  cycle;
        logic [4:0]  reg_idx;
        logic [31:0] data;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    function automatic rec_t make_rec(input logic kind, input logic [7:0] cycle,
                                      input logic [4:0] reg_idx, input logic [31:0] data);
        rec_t r;
        r.kind    = kind;
        r.cycle   = cycle;
        r.reg_idx = reg_idx;
        r.data    = data;
        return r;
    endfunction

endpackage

// File: rtl/reg_dump_sequencer_if.sv
// Record stream toward the host checker: valid/ready handshake plus payload.
interface reg_dump_sequencer_if;

    logic        rec_valid;
    logic        rec_ready;
    logic        rec_kind;
    logic [7:0]  rec_cycle;
    logic [4:0]  rec_reg;
    logic [31:0] rec_data;

    modport master (
        output rec_valid,
        output rec_kind,
        output rec_cycle,
        output rec_reg,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_kind,
        input  rec_cycle,
        input  rec_reg,
        input  rec_data,
        output rec_ready
    );

endinterface

// File: rtl/reg_dump_sequencer_fifo.sv
// First-word-fall-through trace FIFO; head is visible combinationally while
// not empty. Pointers carry one extra wrap bit to tell full from empty.
module trace_fifo
    import reg_dump_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  rec_t din,
    output rec_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic           do_pop;
    logic           do_push;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Run/dump sequencer: logs processor regfile writes during a bounded run, then
// freezes the CPU and streams every register value out on the record port.
module reg_dump_sequencer
    import reg_dump_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_REGS   = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [7:0]                  num_cycles,
    input  logic                        rwe,
    input  logic [4:0]                  rd,
    input  logic [31:0]                 rData,
    input  logic [31:0]                 regA,
    output logic                        cpu_hold,
    output logic                        test_mode,
    output logic [4:0]                  rs1_test,
    reg_dump_sequencer_if.master        rec,
    output logic                        overflow,
    output logic                        busy,
    output logic                        done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  ncyc_q;
    logic [4:0]  idx_q;
    logic [31:0] cap_data_p1;
    logic        ovf_q;
    logic        hold_q;
    logic        tmode_q;

    logic        start_ok;
    logic        trace_phase;
    logic        last_cyc;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    rec_t        push_rec;
    rec_t        head;

    assign start_ok    = start && (state_q == IDLE || state_q == DONE);
    assign trace_phase = (state_q == RUN) || (state_q == DRAIN);
    assign last_cyc    = (cnt_q == ncyc_q - 8'd1);
    assign push        = (state_q == RUN) && rwe && (rd != 5'd0);
    assign pop         = trace_phase && !fifo_empty && rec.rec_ready;
    assign push_rec    = make_rec(REC_TRACE, cnt_q, rd, rData);

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (num_cycles == 8'd0) ? DRAIN : RUN;
            RUN:        if (last_cyc) state_d = DRAIN;
            DRAIN:      if (fifo_empty) state_d = SETTLE;
            SETTLE:     state_d = EMIT;
            EMIT:       if (rec.rec_ready) state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
    end

    // Control registers; hold/test_mode follow the next state so they switch on the entering edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            ncyc_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b0;
            tmode_q <= 1'b0;
        end else begin
            hold_q  <= state_d inside {DRAIN, SETTLE, EMIT, DONE};
            tmode_q <= state_d inside {SETTLE, EMIT, DONE};
            if (start_ok) begin
                cnt_q  <= '0;
                ncyc_q <= num_cycles;
                idx_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (state_q == RUN) cnt_q <= cnt_q + 8'd1;
                if (state_q == EMIT && rec.rec_ready && idx_q != LAST_IDX) idx_q <= idx_q + 5'd1;
                if (push && fifo_full && !pop) ovf_q <= 1'b1;
            end
        end
    end

    // Capture stage: regfile port A settles during SETTLE, sampled at its end.
    always_ff @(posedge clock) begin
        if (state_q == SETTLE) cap_data_p1 <= regA;
    end

    always_comb begin
        rec.rec_valid = 1'b0;
        rec.rec_kind  = REC_TRACE;
        rec.rec_cycle = '0;
        rec.rec_reg   = '0;
        rec.rec_data  = '0;
        if (trace_phase && !fifo_empty) begin
            rec.rec_valid = 1'b1;
            rec.rec_kind  = head.kind;
            rec.rec_cycle = head.cycle;
            rec.rec_reg   = head.reg_idx;
            rec.rec_data  = head.data;
        end else if (state_q == EMIT) begin
            rec.rec_valid = 1'b1;
            rec.rec_kind  = REC_DUMP;
            rec.rec_reg   = idx_q;
            rec.rec_data  = cap_data_p1;
        end
    end

    assign cpu_hold  = hold_q;
    assign test_mode = tmode_q;
    assign rs1_test  = idx_q;
    assign overflow  = ovf_q;
    assign busy      = state_q inside {RUN, DRAIN, SETTLE, EMIT};
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: a regfile model, a record scoreboard built from
// the run/dump rules, per-cycle handshake checks and directed scenarios.
module tb_reg_dump_sequencer;

    localparam int DEPTH = 4;
    localparam int NREGS = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_cycles = '0;
    logic        rwe = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] rData = '0;
    logic [31:0] regA;
    logic        cpu_hold, test_mode, overflow, busy, done;
    logic [4:0]  rs1_test;

    reg_dump_sequencer_if rif ();

    reg_dump_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .NUM_REGS   (NREGS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_cycles (num_cycles),
        .rwe        (rwe),
        .rd         (rd),
        .rData      (rData),
        .regA       (regA),
        .cpu_hold   (cpu_hold),
        .test_mode  (test_mode),
        .rs1_test   (rs1_test),
        .rec        (rif.master),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    logic [31:0] regs [NREGS];
    always_comb regA = test_mode ? regs[rs1_test] : 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [45:0] exp_q [$];
    logic [45:0] obs [$];
    logic [45:0] t1_obs [$];
    int          w_cnt [$];
    int          w_rd [$];
    logic [31:0] w_dat [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [45:0] cur_rec();
        return {rif.rec_kind, rif.rec_cycle, rif.rec_reg, rif.rec_data};
    endfunction

    function automatic logic [56:0] all_outs();
        return {cpu_hold, test_mode, rs1_test, rif.rec_valid, rif.rec_kind, rif.rec_cycle,
                rif.rec_reg, rif.rec_data, overflow, busy, done};
    endfunction

    // Compare process: every record handshake against the scoreboard, plus hold-under-backpressure.
    initial begin
        bit          hold_pend;
        logic [45:0] held;
        logic [45:0] e;
        hold_pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", {63'd0, rif.rec_valid}, 64'd1);
                    chk("hold_record", {18'd0, cur_rec()}, {18'd0, held});
                end
                hold_pend = rif.rec_valid && !rif.rec_ready;
                held = cur_rec();
                if (rif.rec_valid && rif.rec_ready) begin
                    obs.push_back(cur_rec());
                    if (exp_q.size() == 0) begin
                        chk("unexpected_record", {18'd0, cur_rec()}, 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("record", {18'd0, cur_rec()}, {18'd0, e});
                    end
                end
            end
        end
    end

    task automatic add_w(input int c, input int r, input logic [31:0] d);
        w_cnt.push_back(c);
        w_rd.push_back(r);
        w_dat.push_back(d);
    endtask

    task automatic clr_w();
        w_cnt.delete();
        w_rd.delete();
        w_dat.delete();
    endtask

    task automatic run_test(input int ncyc, input bit ready_low, input bit poke,
                            input bit stall, input bit abort, output bit aborted);
        int kept;
        int nz;
        bit poked;
        bit stalled;
        aborted = 1'b0;
        poked = 1'b0;
        stalled = 1'b0;
        obs.delete();
        kept = 0;
        nz = 0;
        // Trace expectations: writes to r0 vanish; with the consumer stalled only DEPTH fit.
        foreach (w_cnt[i]) begin
            if (w_rd[i] != 0 && w_cnt[i] < ncyc) begin
                nz++;
                if (!ready_low || kept < DEPTH) begin
                    exp_q.push_back({1'b0, 8'(w_cnt[i]), 5'(w_rd[i]), w_dat[i]});
                    kept++;
                end
            end
        end
        rif.rec_ready = !ready_low;
        num_cycles = 8'(ncyc);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        num_cycles = 8'hFF;
        chk("ovf_clear_on_start", {63'd0, overflow}, 64'd0);
        chk("test_mode_clear_on_start", {63'd0, test_mode}, 64'd0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("cpu_hold_after_start", {63'd0, cpu_hold}, (ncyc == 0) ? 64'd1 : 64'd0);
        for (int k = 0; k < ncyc; k++) begin
            foreach (w_cnt[i]) begin
                if (w_cnt[i] == k) begin
                    rwe = 1'b1;
                    rd = 5'(w_rd[i]);
                    rData = w_dat[i];
                end
            end
            if (poke && k == 2) begin
                start = 1'b1;
                num_cycles = 8'd1;
            end
            @(posedge clock); #1;
            if (rwe && rd != 5'd0) regs[rd] = rData;
            rwe = 1'b0;
            start = 1'b0;
            num_cycles = 8'hFF;
        end
        if (ready_low) chk("overflow_after_run", {63'd0, overflow}, (nz > DEPTH) ? 64'd1 : 64'd0);
        rif.rec_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) exp_q.push_back({1'b1, 8'h00, 5'(i), regs[i]});
        for (int c = 0; c < 400; c++) begin
            if (done) break;
            @(posedge clock); #1;
            start = 1'b0;
            if (rif.rec_valid && rif.rec_kind && rif.rec_reg == 5'd3 && stall && !stalled) begin
                stalled = 1'b1;
                rif.rec_ready = 1'b0;
                repeat (5) begin @(posedge clock); #1; end
                chk("stall_valid", {63'd0, rif.rec_valid}, 64'd1);
                chk("stall_reg", {59'd0, rif.rec_reg}, 64'd3);
                chk("stall_data", {32'd0, rif.rec_data}, 64'h1000_0009);
                chk("stall_rs1", {59'd0, rs1_test}, 64'd3);
                rif.rec_ready = 1'b1;
            end
            if (poke && !poked && rif.rec_valid && rif.rec_kind && rif.rec_reg == 5'd5) begin
                poked = 1'b1;
                start = 1'b1;
                num_cycles = 8'd0;
            end
            if (abort && rif.rec_valid && rif.rec_kind && rif.rec_reg == 5'd10) begin
                #2 reset = 1'b0;
                #1 chk("abort_outputs_zero", {7'd0, all_outs()}, 64'd0);
                exp_q.delete();
                @(negedge clock);
                reset = 1'b1;
                aborted = 1'b1;
                return;
            end
        end
        num_cycles = 8'h00;
        chk("done", {63'd0, done}, 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_flags", {60'd0, busy, cpu_hold, test_mode, rif.rec_valid}, 64'b0110);
    endtask

    initial begin
        bit ab;
        bit same;
        regs[0] = 32'h0;
        for (int i = 1; i < NREGS; i++) regs[i] = 32'h1000_0000 + 32'(i * 3);
        rif.rec_ready = 1'b1;
        #2 reset = 1'b0;
        #2 chk("reset_outputs_zero", {7'd0, all_outs()}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Basic run with an r0 write and a 5-cycle stall at dump index 3.
        clr_w();
        add_w(1, 2, 32'd5);
        add_w(2, 0, 32'd9);
        add_w(3, 7, 32'hFFFF_FFFF);
        run_test(4, 1'b0, 1'b0, 1'b1, 1'b0, ab);
        chk("t1_count", 64'(obs.size()), 64'd34);
        if (obs.size() == 34) begin
            chk("t1_rec0", {18'd0, obs[0]}, {18'd0, 1'b0, 8'd1, 5'd2, 32'd5});
            chk("t1_rec1", {18'd0, obs[1]}, {18'd0, 1'b0, 8'd3, 5'd7, 32'hFFFF_FFFF});
            chk("t1_dump_r0", {18'd0, obs[2]}, {18'd0, 1'b1, 8'd0, 5'd0, 32'd0});
            chk("t1_dump_r7", {18'd0, obs[9]}, {18'd0, 1'b1, 8'd0, 5'd7, 32'hFFFF_FFFF});
            chk("t1_dump_r31", {18'd0, obs[33]}, {18'd0, 1'b1, 8'd0, 5'd31, 32'h1000_005D});
        end
        t1_obs = obs;

        // Same run with ignored start pulses during RUN and EMIT.
        run_test(4, 1'b0, 1'b1, 1'b0, 1'b0, ab);
        same = (obs.size() == t1_obs.size());
        if (same) foreach (obs[i]) if (obs[i] !== t1_obs[i]) same = 1'b0;
        chk("poke_sequence_identical", {63'd0, same}, 64'd1);

        // Consumer stalled through RUN: six writes into a four-deep FIFO.
        clr_w();
        for (int k = 0; k < 6; k++) add_w(k, k + 1, 32'hA0 + 32'(k));
        run_test(6, 1'b1, 1'b0, 1'b0, 1'b0, ab);
        chk("ovf_count", 64'(obs.size()), 64'd36);
        if (obs.size() == 36) begin
            chk("ovf_rec0", {18'd0, obs[0]}, {18'd0, 1'b0, 8'd0, 5'd1, 32'hA0});
            chk("ovf_rec3", {18'd0, obs[3]}, {18'd0, 1'b0, 8'd3, 5'd4, 32'hA3});
            chk("ovf_dump_r6", {18'd0, obs[10]}, {18'd0, 1'b1, 8'd0, 5'd6, 32'hA5});
        end
        chk("ovf_sticky_at_done", {63'd0, overflow}, 64'd1);

        // Zero-length run goes straight to the dump.
        clr_w();
        run_test(0, 1'b0, 1'b0, 1'b0, 1'b0, ab);
        chk("zero_count", 64'(obs.size()), 64'd32);
        if (obs.size() > 0) chk("zero_first", {18'd0, obs[0]}, {18'd0, 1'b1, 8'd0, 5'd0, 32'd0});

        // Reset in the middle of the dump, then a complete fresh dump.
        run_test(3, 1'b0, 1'b0, 1'b0, 1'b1, ab);
        chk("abort_taken", {63'd0, ab}, 64'd1);
        @(posedge clock); #1;
        run_test(2, 1'b0, 1'b0, 1'b0, 1'b0, ab);
        chk("after_abort_count", 64'(obs.size()), 64'd32);
        if (obs.size() > 0) chk("after_abort_first", {18'd0, obs[0]}, {18'd0, 1'b1, 8'd0, 5'd0, 32'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
